// File: rtl/bcd_timer_pkg.sv
// timer_pkg: shared FSM state type, BCD digit width and digit limits for bcd_timer.
package timer_pkg;
    localparam int DIGIT_W = 4;
    typedef logic [DIGIT_W-1:0] digit_t;
    localparam digit_t LIM_NINE = 4'd9;
    localparam digit_t LIM_FIVE = 4'd5;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
endpackage

// File: rtl/bcd_timer_digit.sv
// bcd_digit: one mod-(LIMIT+1) BCD digit with increment in and carry out.
module bcd_digit
    import timer_pkg::*;
#(
    parameter digit_t LIMIT = LIM_NINE
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   inc,
    output digit_t value,
    output logic   carry
);
    // >= rather than == so an out-of-range value still folds back to zero
    assign carry = inc && (value >= LIMIT);
    always_ff @(posedge clk) begin
        if (rst || clr) value <= '0;
        else if (inc) value <= (value >= LIMIT) ? '0 : value + 1'b1;
    end
endmodule

// File: rtl/bcd_timer.sv
// bcd_timer: MM:SS stopwatch counting rising edges of a divided tick input.
// Optional lap hold of the displayed digits is built with BCD_TIMER_LAP_HOLD_EN.
module bcd_timer
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 6
) (
    input  logic               I_CLK,
    input  logic               rst,
    input  logic               I_TICK,
    input  logic               I_START,
    input  logic               I_STOP,
    input  logic               I_CLR,
    input  logic               I_LAP,
    output logic [DIGIT_W-1:0] O_SEC_ONES,
    output logic [DIGIT_W-1:0] O_SEC_TENS,
    output logic [DIGIT_W-1:0] O_MIN_ONES,
    output logic [DIGIT_W-1:0] O_MIN_TENS,
    output logic               O_RUN,
    output logic               O_WRAP
);
    localparam logic [7:0] PS_LAST = 8'(TICKS_PER_SEC - 1);
    state_t state, state_next;
    logic tick_d, tick_edge, count_tick, sec_inc;
    logic [7:0] presc;
    logic [3:0] carry;
    digit_t sec_ones, sec_tens, min_ones, min_tens;
    logic [4*DIGIT_W-1:0] live, shown;
    assign tick_edge = I_TICK & ~tick_d;
    always_ff @(posedge I_CLK) begin
        if (rst) begin
            state  <= IDLE;
            tick_d <= 1'b0;
        end else begin
            state  <= state_next;
            tick_d <= I_TICK;
        end
    end
    // clear dominates stop, stop dominates start; stop outside RUN changes nothing
    always_comb begin
        state_next = I_CLR ? IDLE :
                     I_STOP ? ((state == RUN) ? PAUSE : state) :
                     I_START ? RUN : state;
    end
    assign count_tick = (state == RUN) && tick_edge && !I_CLR && !I_STOP;
    assign sec_inc    = count_tick && (presc >= PS_LAST);
    always_ff @(posedge I_CLK) begin
        if (rst || I_CLR || state == IDLE) presc <= '0;
        else if (count_tick) presc <= (presc >= PS_LAST) ? '0 : presc + 8'd1;
    end
    bcd_digit #(.LIMIT(LIM_NINE)) u_sec_ones (
        .clk(I_CLK), .rst(rst), .clr(I_CLR), .inc(sec_inc),
        .value(sec_ones), .carry(carry[0])
    );
    bcd_digit #(.LIMIT(LIM_FIVE)) u_sec_tens (
        .clk(I_CLK), .rst(rst), .clr(I_CLR), .inc(carry[0]),
        .value(sec_tens), .carry(carry[1])
    );
    bcd_digit #(.LIMIT(LIM_NINE)) u_min_ones (
        .clk(I_CLK), .rst(rst), .clr(I_CLR), .inc(carry[1]),
        .value(min_ones), .carry(carry[2])
    );
    bcd_digit #(.LIMIT(LIM_FIVE)) u_min_tens (
        .clk(I_CLK), .rst(rst), .clr(I_CLR), .inc(carry[2]),
        .value(min_tens), .carry(carry[3])
    );
    assign live = {min_tens, min_ones, sec_tens, sec_ones};
    always_ff @(posedge I_CLK) begin
        if (rst) O_WRAP <= 1'b0;
        else O_WRAP <= carry[3];
    end
`ifdef BCD_TIMER_LAP_HOLD_EN
    logic lap_d, lap_edge, hold;
    logic [4*DIGIT_W-1:0] held;
    assign lap_edge = I_LAP & ~lap_d;
    // the frozen copy is taken from the value on display when the lap edge arrives
    always_ff @(posedge I_CLK) begin
        if (rst) begin
            lap_d <= 1'b0;
            hold  <= 1'b0;
            held  <= '0;
        end else begin
            lap_d <= I_LAP;
            if (I_CLR) hold <= 1'b0;
            else if (lap_edge) hold <= !hold && (state == RUN);
            if (lap_edge && !hold) held <= live;
        end
    end
    assign shown = hold ? held : live;
`else
    logic lap_unused;
    assign lap_unused = I_LAP;
    assign shown      = live;
`endif
    assign O_SEC_ONES = shown[DIGIT_W-1:0];
    assign O_SEC_TENS = shown[2*DIGIT_W-1:DIGIT_W];
    assign O_MIN_ONES = shown[3*DIGIT_W-1:2*DIGIT_W];
    assign O_MIN_TENS = shown[4*DIGIT_W-1:3*DIGIT_W];
    assign O_RUN      = (state == RUN);
endmodule
